// File: rtl/hazard_controller.sv
// Pipeline sequencer for a 5-stage rv32i core: load-use bubbles, cache-miss freezes,
// taken-branch flushes with a redirect held across an outstanding fetch, and perf counters.
module hazard_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             if_id_use_rs1,
  input  logic             if_id_use_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_ld_regfile,
  input  logic             id_ex_dmem_read,
  input  logic             imem_read,
  input  logic             imem_resp,
  input  logic             dmem_read,
  input  logic             dmem_write,
  input  logic             dmem_resp,
  input  logic             br_taken_ex,
  input  logic [31:0]      br_target_ex,
  output logic             ld_pc,
  output logic             ld_if_id,
  output logic             ld_id_ex,
  output logic             ld_ex_mem,
  output logic             ld_mem_wb,
  output logic             bubble_id_ex,
  output logic             flush_if_id,
  output logic             pc_redirect,
  output logic [31:0]      pc_redirect_addr,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] lu_cnt
);

  typedef enum logic {RUN, REDIRECT_WAIT} state_e;

  state_e             state_q, state_d;
  logic [31:0]        redirect_q, redirect_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]   lu_cnt_q, lu_cnt_d;
  logic               dbusy, ibusy, lu, lu_bubble;

  assign dbusy = (dmem_read | dmem_write) & ~dmem_resp;
  assign ibusy = imem_read & ~imem_resp;
  // A load into x0 never produces a value, so it cannot create a hazard.
  assign lu    = id_ex_dmem_read & id_ex_ld_regfile & (id_ex_rd != 5'd0) &
                 ((if_id_use_rs1 & (id_ex_rd == if_id_rs1)) |
                  (if_id_use_rs2 & (id_ex_rd == if_id_rs2)));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      redirect_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      lu_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      redirect_q  <= redirect_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      lu_cnt_q    <= lu_cnt_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    redirect_d = redirect_q;
    unique case (state_q)
      RUN: begin
        if (!dbusy && br_taken_ex && ibusy) begin
          state_d    = REDIRECT_WAIT;
          redirect_d = br_target_ex;
        end
      end
      REDIRECT_WAIT: begin
        if (!ibusy) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Outputs are gated by rst_n so the whole pipe is frozen the instant reset asserts.
  always_comb begin
    ld_pc            = 1'b0;
    ld_if_id         = 1'b0;
    ld_id_ex         = 1'b0;
    ld_ex_mem        = 1'b0;
    ld_mem_wb        = 1'b0;
    bubble_id_ex     = 1'b0;
    flush_if_id      = 1'b0;
    pc_redirect      = 1'b0;
    pc_redirect_addr = '0;
    lu_bubble        = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        RUN: begin
          if (dbusy) begin
            // whole pipe frozen; a branch in EX is re-evaluated once data returns
          end else if (br_taken_ex && !ibusy) begin
            {ld_pc, ld_if_id, ld_id_ex, ld_ex_mem, ld_mem_wb} = '1;
            pc_redirect      = 1'b1;
            pc_redirect_addr = br_target_ex;
            flush_if_id      = 1'b1;
            bubble_id_ex     = 1'b1;
          end else if (br_taken_ex) begin
            {ld_id_ex, ld_ex_mem, ld_mem_wb} = '1;
            bubble_id_ex = 1'b1;
          end else if (ibusy) begin
            // fetch outstanding: hold everything
          end else if (lu) begin
            {ld_id_ex, ld_ex_mem, ld_mem_wb} = '1;
            bubble_id_ex = 1'b1;
            lu_bubble    = 1'b1;
          end else begin
            {ld_pc, ld_if_id, ld_id_ex, ld_ex_mem, ld_mem_wb} = '1;
          end
        end
        REDIRECT_WAIT: begin
          if (!dbusy) begin
            {ld_id_ex, ld_ex_mem, ld_mem_wb} = '1;
            bubble_id_ex = 1'b1;
          end
          if (!ibusy) begin
            ld_pc            = 1'b1;
            ld_if_id         = 1'b1;
            pc_redirect      = 1'b1;
            pc_redirect_addr = redirect_q;
            flush_if_id      = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q + (ld_pc ? CNT_W'(0) : CNT_W'(1));
    flush_cnt_d = flush_cnt_q + (flush_if_id ? CNT_W'(1) : CNT_W'(0));
    lu_cnt_d    = lu_cnt_q + (lu_bubble ? CNT_W'(1) : CNT_W'(0));
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign lu_cnt    = lu_cnt_q;

endmodule
